// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types for the serial magnitude comparator: FSM states and the {lt,gt,eq} result encoding.
package serial_magnitude_comparator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int unsigned RES_W = 3;

    // One-hot {lt, gt, eq}; RES_NONE only exists between reset and the first Done.
    typedef logic [RES_W-1:0] res_t;

    localparam res_t RES_NONE = 3'b000;
    localparam res_t RES_LT   = 3'b100;
    localparam res_t RES_GT   = 3'b010;
    localparam res_t RES_EQ   = 3'b001;

    function automatic res_t digit_res(input logic lt, input logic gt);
        if (lt) return RES_LT;
        if (gt) return RES_GT;
        return RES_EQ;
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// Start/Done request bus of the serial magnitude comparator: operands, mode, cascade in, result out.
interface serial_magnitude_comparator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             ready;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             lt_in;
    logic             gt_in;
    logic             eq_in;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    modport master (
        output start, signed_mode, a, b, lt_in, gt_in, eq_in,
        input  ready, done, lt, gt, eq
    );

    modport slave (
        input  start, signed_mode, a, b, lt_in, gt_in, eq_in,
        output ready, done, lt, gt, eq
    );

endinterface

// File: rtl/serial_magnitude_comparator_digit_comparator.sv
// Combinational unsigned compare of one DIGIT-bit slice.
module digit_comparator #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             lt_c_o,
    output logic             gt_c_o,
    output logic             eq_c_o
);

    assign lt_c_o = (a_i <  b_i);
    assign gt_c_o = (a_i >  b_i);
    assign eq_c_o = (a_i == b_i);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator, MSD first, with signed mode and Lt/Gt/Eq cascade.
// Define EARLY_EXIT_EN to finish on the first deciding digit instead of always taking N steps.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    serial_magnitude_comparator_if.slave  bus
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] a_q,       a_d;
    logic [WIDTH-1:0] b_q,       b_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             decided_q, decided_d;
    res_t             dec_res_q, dec_res_d;
    res_t             res_q,     res_d;
    logic             done_q,    done_d;
    logic             ready_q,   ready_d;

    logic [DIGIT-1:0] dig_a_c;
    logic [DIGIT-1:0] dig_b_c;
    logic             dig_lt_c;
    logic             dig_gt_c;
    logic             dig_eq_c;
    res_t             step_res_c;
    logic             finish_c;
    logic [WIDTH-1:0] sign_mask_c;

    // Select the digit addressed by the step index, most significant first.
    always_comb begin
        dig_a_c = '0;
        dig_b_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_a_c = a_q[WIDTH-1-i*DIGIT -: DIGIT];
                dig_b_c = b_q[WIDTH-1-i*DIGIT -: DIGIT];
            end
        end
    end

    digit_comparator #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_i    (dig_a_c),
        .b_i    (dig_b_c),
        .lt_c_o (dig_lt_c),
        .gt_c_o (dig_gt_c),
        .eq_c_o (dig_eq_c)
    );

    // A decision already taken (cascade or earlier digit) overrides the current digit.
    assign step_res_c  = decided_q ? dec_res_q : digit_res(dig_lt_c, dig_gt_c);
    assign sign_mask_c = {bus.signed_mode, {(WIDTH-1){1'b0}}};

`ifdef EARLY_EXIT_EN
    assign finish_c = (idx_q == IDX_LAST) || (step_res_c != RES_EQ);
`else
    assign finish_c = (idx_q == IDX_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        dec_res_d = dec_res_q;
        res_d     = res_q;
        done_d    = 1'b0;
        ready_d   = ready_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    // Flipping the sign bit maps two's complement order onto unsigned order.
                    a_d       = bus.a ^ sign_mask_c;
                    b_d       = bus.b ^ sign_mask_c;
                    idx_d     = '0;
                    decided_d = !bus.eq_in;
                    dec_res_d = bus.gt_in ? RES_GT : RES_LT;
                    state_d   = ST_COMPARE;
                    ready_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_COMPARE: begin
                if (finish_c) begin
                    res_d   = step_res_c;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (!decided_q && !dig_eq_c) begin
                        decided_d = 1'b1;
                        dec_res_d = step_res_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            dec_res_q <= RES_NONE;
            res_q     <= RES_NONE;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            dec_res_q <= dec_res_d;
            res_q     <= res_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.done  = done_q;
    assign bus.lt    = res_q[2];
    assign bus.gt    = res_q[1];
    assign bus.eq    = res_q[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (WIDTH=16, DIGIT=4); follows EARLY_EXIT_EN for Done timing.
module tb_serial_magnitude_comparator;
    import serial_magnitude_comparator_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIGIT = 4;
    localparam int unsigned N     = WIDTH / DIGIT;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sgn;
        logic             lt_in;
        logic             gt_in;
        logic             eq_in;
        res_t             exp;
    } vec_t;

    typedef struct {
        res_t res;
        int   due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   edge_n   = 0;
    exp_t sb[$];
    vec_t tbl[12];

    serial_magnitude_comparator_if #(.WIDTH(WIDTH)) bus ();

    serial_magnitude_comparator #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic res_t cur_res();
        return {bus.lt, bus.gt, bus.eq};
    endfunction

    // Done latency in cycles after the Start edge.
    function automatic int exp_lat(input vec_t v);
`ifdef EARLY_EXIT_EN
        logic [WIDTH-1:0] fa;
        logic [WIDTH-1:0] fb;
        if (!v.eq_in) return 1;
        fa = v.a;
        fb = v.b;
        for (int i = 0; i < int'(N); i++) begin
            if (fa[WIDTH-1-i*DIGIT -: DIGIT] != fb[WIDTH-1-i*DIGIT -: DIGIT]) return i + 1;
        end
        return int'(N);
`else
        return int'(N);
`endif
    endfunction

    // Scoreboard consumer: every Done must match the oldest outstanding expectation.
    always @(posedge clk) begin
        exp_t e;
        edge_n = edge_n + 1;
        #1;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result", 32'(cur_res()), 32'(e.res));
                check("done_edge", 32'(edge_n), 32'(e.due));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.a           = v.a;
        bus.b           = v.b;
        bus.signed_mode = v.sgn;
        bus.lt_in       = v.lt_in;
        bus.gt_in       = v.gt_in;
        bus.eq_in       = v.eq_in;
        bus.start       = 1'b1;
    endtask

    // Present one request; returns whether Ready allowed it to be taken.
    task automatic start_vec(input vec_t v, input logic push_en, output logic acc);
        exp_t e;
        @(negedge clk);
        drive(v);
        acc = bus.ready;
        @(posedge clk);
        #1;
        if (acc && push_en) begin
            e.res = v.exp;
            e.due = edge_n + exp_lat(v);
            sb.push_back(e);
        end
        bus.start = 1'b0;
        bus.a     = 16'($urandom);
        bus.b     = 16'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t v2;
        logic acc;
        exp_t e;

        tbl[0]  = '{16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, RES_EQ};
        tbl[1]  = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, RES_GT};
        tbl[2]  = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1, RES_LT};
        tbl[3]  = '{16'h12F0, 16'h12E0, 1'b0, 1'b0, 1'b0, 1'b1, RES_GT};
        tbl[4]  = '{16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, RES_GT};
        tbl[5]  = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, RES_LT};
        tbl[6]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, RES_LT};
        tbl[7]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, RES_GT};
        tbl[8]  = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, RES_GT};
        tbl[9]  = '{16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1, RES_GT};
        tbl[10] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, RES_EQ};
        tbl[11] = '{16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, RES_LT};

        bus.start = 1'b0; bus.signed_mode = 1'b0;
        bus.a = '0; bus.b = '0;
        bus.lt_in = 1'b0; bus.gt_in = 1'b0; bus.eq_in = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(cur_res()), 32'(RES_NONE));
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            start_vec(tbl[i], 1'b1, acc);
            check("accept", 32'(acc), 32'd1);
            check("busy_ready", 32'(bus.ready), 32'd0);
            wait_idle();
            check("hold", 32'(cur_res()), 32'(tbl[i].exp));
        end

        // Reset two edges into a compare: no Done, outputs back to reset values.
        start_vec(tbl[0], 1'b0, acc);
        @(negedge clk);
        check("abort_busy", 32'(bus.ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(cur_res()), 32'(RES_NONE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_result_after", 32'(cur_res()), 32'(RES_NONE));

        // Start pulsed while busy is dropped.
        v2 = '{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, RES_LT};
        start_vec(tbl[0], 1'b1, acc);
        start_vec(v2, 1'b1, acc);
        check("busy_start_ignored", 32'(acc), 32'd0);
        wait_idle();
        repeat (6) @(negedge clk);
        check("busy_hold", 32'(cur_res()), 32'(RES_EQ));

        // Back-to-back: Start held through the Done cycle with new operands.
        v = '{16'hF0F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b1, RES_GT};
        @(negedge clk);
        drive(v);
        check("b2b_ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        e.res = v.exp;
        e.due = edge_n + exp_lat(v);
        sb.push_back(e);
        @(negedge clk);
        drive(v2);
        for (int i = 0; i < 20 && bus.ready !== 1'b1; i++) @(negedge clk);
        check("b2b_in_done_cycle", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        e.res = v2.exp;
        e.due = edge_n + exp_lat(v2);
        sb.push_back(e);
        bus.start = 1'b0;
        check("b2b_second_busy", 32'(bus.ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_stable", 32'(cur_res()), 32'(RES_GT));
        end
        wait_idle();
        check("b2b_final", 32'(cur_res()), 32'(RES_LT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequential, parametrised magnitude comparator for WIDTH-bit operands. It resolves DIGIT bits per clock, most significant digit first, and supports signed/unsigned mode. Lt/Gt/Eq cascade inputs let a more-significant word's result chain into this one. It sits wherever datapath blocks need a compare of wide operands without a WIDTH-deep combinational chain, and is started and completed through a Start/Done handshake.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits resolved per cycle; N = WIDTH/DIGIT digit steps.
- Clk  input  1  single clock, rising edge.
- ResetN  input  1  synchronous, active-low reset.
- Start  input  1  request; accepted only when Ready=1.
- Ready  output  1  block can accept Start.
- Signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with Start.
- A, B  input  WIDTH  operands; sampled with Start.
- LtIn, GtIn, EqIn  input  1 each  cascade result of the more-significant word; sampled with Start.
- Done  output  1  one-cycle pulse, result valid.
- Lt, Gt, Eq  output  1 each  result (A<B, A>B, A==B); exactly one high after the first Done.

## Operation
- States: IDLE, COMPARE, DONE. Reset → IDLE; Ready=1, Done=0, Lt=Gt=Eq=0.
- IDLE/DONE with Start=1: latch A, B, Signed and cascade; index=0; go to COMPARE. Ready=0 in COMPARE.
- Signed=1: invert bit WIDTH-1 of both latched operands, then compare unsigned.
- Cascade priority: EqIn=1 → compare operands; else GtIn=1 → result Gt; else → result Lt. The operands are ignored in both non-equal cases.
- COMPARE step i (i=0..N-1) compares bits [WIDTH-1-i·DIGIT -: DIGIT].
  - The first differing digit decides Gt/Lt.
  - Later digits are not examined; the decision is sticky.
  - All digits equal → Eq.
- Final step → DONE for one cycle: Done=1, Lt/Gt/Eq updated, Ready=1. Without a new Start, DONE → IDLE on the next cycle.
- Lt/Gt/Eq hold the last result until the next Done or reset. They do not change during COMPARE.
- Start while Ready=0 is ignored; there is no queuing.

## Timing
- Start sampled at edge k.
- Constant latency: Done and results are registered at edge k+N (N cycles). Done is high for exactly one cycle.
- Early exit (see Configuration): Done at edge k+j, where j is the 1-based index of the first differing digit. A non-equal cascade gives j=1.
- Back-to-back: Start may be asserted in the Done cycle and is accepted. The next result follows the same latency, with no idle gap.
- ResetN=0 at any edge, including mid-COMPARE: abort, IDLE, all outputs to reset values at that edge. No Done is produced for the aborted compare.
- Operands may change after the Start edge without effect.

## Configuration
- EARLY_EXIT_EN defined: COMPARE terminates on the first differing digit or a non-equal cascade (variable latency 1..N).
- Undefined: always N cycles, regardless of data. Results are identical in both builds; only Done timing differs.

## Structure
- Package serial_magnitude_comparator_pkg: state enum typedef (IDLE, COMPARE, DONE); result encoding constants (RES_LT, RES_GT, RES_EQ).
- Sub-module digit_comparator: combinational DIGIT-bit compare producing lt/gt/eq, instantiated once and fed the current digit by a mux on the index.
- Top module holds the FSM, the operand registers, the index counter (clog2(N) bits) and the result registers.

## Test plan
- WIDTH=16, DIGIT=4, A=0x1234, B=0x1234, EqIn=1, Signed=0 → Eq=1, Done at k+4 in both builds.
- A=0x8000, B=0x7FFF, Signed=0 → Gt=1; Done at k+1 with EARLY_EXIT_EN, k+4 without. Same operands with Signed=1 → Lt=1.
- A=0x12F0, B=0x12E0 → Gt=1; Done at k+3 with EARLY_EXIT_EN.
- EqIn=0, GtIn=1, A=0x0001, B=0xFFFF → Gt=1 (operands ignored); EqIn=0, LtIn=1, A=B → Lt=1.
- Reset and busy handling:
  - Start at k, ResetN=0 at k+2 → no Done; Lt=Gt=Eq=0; Ready=1 after that edge.
  - Start pulsed at k+1 (busy) → ignored, no second Done.
- Back-to-back:
  - Start held high through the Done cycle with new A=0x0001, B=0x0002 → first result Done, then Lt=1 after N more cycles.
  - Lt/Gt/Eq stable between the two Dones.
